// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

    // Index width for n sources, never narrower than one bit.
    function automatic int src_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_inc(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_picker.sv
// Round-robin picker: first requester at or after rr_ptr, wrapping.
// Latency: combinational.
// Backpressure: none.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_SRC = 4,
    localparam int SRC_W   = src_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   rr_ptr,
    output logic               found,
    output logic [SRC_W-1:0]   idx
);

    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    int                   off;
    int                   sum;

    always_comb begin
        dbl   = {req, req};
        rot   = NUM_SRC'(dbl >> rr_ptr);
        found = 1'b0;
        off   = 0;
        // Scan downwards so the lowest rotated offset wins.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = k;
            end
        end
        sum = int'(rr_ptr) + off;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        idx = SRC_W'(sum);
    end

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, DEPTH entries of WIDTH bits.
// Latency: a written entry is readable on the next cycle.
// Backpressure: in_rdy low when full; out_vld low when empty.
module sync_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    localparam int AW      = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign in_rdy  = (count != (AW+1)'(DEPTH));
    assign out_vld = (count != '0);
    assign out_dat = mem[rptr];
    assign do_wr   = in_vld && in_rdy;
    assign do_rd   = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= in_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
            end
            if (do_rd) begin
                rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count <= count + 1'b1;
            end else if (!do_wr && do_rd) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Burst-locked round-robin arbiter feeding one FIFO write port, source-tagged.
// Latency: one cycle from accept to out_*.
// Backpressure: src_ready follows load = !out_valid | out_ready; out_* hold while stalled.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  NUM_SRC    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  MAX_BURST  = 4,
    localparam int SRC_W      = src_w(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          clear,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC-1:0]            src_last,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SRC_W-1:0]              out_src,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t             state;
    logic [SRC_W-1:0]       rr_ptr;
    logic [SRC_W-1:0]       cur;
    logic [CNT_W-1:0]       beat_cnt;
    logic [DATA_WIDTH-1:0]  src_beat [NUM_SRC];
    logic                   pick_found;
    logic [SRC_W-1:0]       pick_idx;
    logic                   flush;
    logic                   load;
    logic [SRC_W-1:0]       sel;
    logic                   sel_vld;
    logic                   accept;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_beat[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_priority_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .req    (src_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    assign flush   = !rstn || clear;
    assign load    = !out_valid || out_ready;
    assign sel     = (state == ARB_IDLE) ? pick_idx : cur;
    assign sel_vld = (state == ARB_IDLE) ? pick_found : src_valid[cur];
    assign accept  = !flush && sel_vld && load;
    assign busy    = (state == ARB_BURST);

    always_comb begin
        src_ready = '0;
        if (accept) begin
            src_ready[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            cur       <= '0;
            beat_cnt  <= '0;
        end else begin
            if (load) begin
                out_valid <= accept;
                if (accept) begin
                    out_data <= src_beat[sel];
                    out_src  <= sel;
                    out_last <= src_last[sel];
                end
            end

            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        if (!src_last[sel] && MAX_BURST > 1) begin
                            state    <= ARB_BURST;
                            cur      <= sel;
                            beat_cnt <= CNT_W'(1);
                        end else begin
                            rr_ptr <= SRC_W'(wrap_inc(int'(sel), NUM_SRC));
                        end
                    end
                end
                ARB_BURST: begin
                    // A source dropping valid mid-burst gives up the rest of its grant.
                    if (!src_valid[cur]) begin
                        state    <= ARB_IDLE;
                        rr_ptr   <= SRC_W'(wrap_inc(int'(cur), NUM_SRC));
                        beat_cnt <= '0;
                    end else if (accept) begin
                        if (src_last[cur] || (beat_cnt + 1'b1 == CNT_W'(MAX_BURST))) begin
                            state    <= ARB_IDLE;
                            rr_ptr   <= SRC_W'(wrap_inc(int'(cur), NUM_SRC));
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus randomized traffic.
// Latency: expected out_* one cycle after accept, from a grant-level reference model.
// Backpressure: out_ready from the bench or from a depth-8 FIFO.
module tb_fifo_write_arbiter;

    localparam int NUM_SRC   = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic                  clk;
    logic                  rstn;
    logic                  clear;
    logic [NUM_SRC*DW-1:0] src_data;
    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC-1:0]    src_last;
    logic [NUM_SRC-1:0]    src_ready;
    logic [DW-1:0]         out_data;
    logic [1:0]            out_src;
    logic                  out_last;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;

    logic                  tb_out_ready;
    logic                  use_fifo;
    logic                  f_in_rdy;
    logic                  f_out_vld;
    logic                  f_out_rdy;
    logic [10:0]           f_out_dat;
    logic [3:0]            f_count;

    // Reference model: current grant owner (-1 = none), beats in grant, next-priority source.
    int                    m_owner;
    int                    m_beats;
    int                    m_rr;
    logic                  m_ov;
    logic                  m_ol;
    logic [DW-1:0]         m_od;
    logic [1:0]            m_os;

    int                    tests;
    int                    fails;

    assign out_ready = use_fifo ? f_in_rdy : tb_out_ready;

    fifo_write_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_last  (src_last),
        .src_ready (src_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    sync_fifo #(
        .WIDTH (11),
        .DEPTH (8)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .in_vld  (out_valid),
        .in_rdy  (f_in_rdy),
        .in_dat  ({out_last, out_src, out_data}),
        .out_vld (f_out_vld),
        .out_rdy (f_out_rdy),
        .out_dat (f_out_dat),
        .count   (f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_predict(output logic [NUM_SRC-1:0] rdy, output int acc, output bit rel);
        int win;
        bit load;
        rdy = '0;
        acc = -1;
        rel = 1'b0;
        win = -1;
        if (!rstn || clear) return;
        load = !m_ov || out_ready;
        if (m_owner < 0) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (win < 0 && src_valid[(m_rr + k) % NUM_SRC]) win = (m_rr + k) % NUM_SRC;
            end
        end else if (src_valid[m_owner]) begin
            win = m_owner;
        end else begin
            rel = 1'b1;
        end
        if (win >= 0 && load) begin
            rdy[win] = 1'b1;
            acc = win;
        end
    endtask

    task automatic model_commit(input int acc, input bit rel);
        bit load;
        if (!rstn || clear) begin
            m_ov = 1'b0; m_od = '0; m_os = '0; m_ol = 1'b0;
            m_owner = -1; m_beats = 0; m_rr = 0;
            return;
        end
        load = !m_ov || out_ready;
        if (load) begin
            m_ov = (acc >= 0);
            if (acc >= 0) begin
                m_od = src_data[acc*DW +: DW];
                m_os = 2'(acc);
                m_ol = src_last[acc];
            end
        end
        if (rel) begin
            m_rr = (m_owner + 1) % NUM_SRC;
            m_owner = -1;
            m_beats = 0;
        end else if (acc >= 0) begin
            m_beats = (m_owner < 0) ? 1 : m_beats + 1;
            if (src_last[acc] || m_beats == MAX_BURST) begin
                m_owner = -1;
                m_rr = (acc + 1) % NUM_SRC;
                m_beats = 0;
            end else begin
                m_owner = acc;
            end
        end
    endtask

    // One clock: sample src_ready mid-cycle, advance the model, land #1 after the edge.
    task automatic tick(output logic [NUM_SRC-1:0] exp_rdy, output logic [NUM_SRC-1:0] got_rdy);
        int acc;
        bit rel;
        #3;
        got_rdy = src_ready;
        model_predict(exp_rdy, acc, rel);
        model_commit(acc, rel);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [NUM_SRC-1:0] e, g;
        rstn = 1'b0; clear = 1'b0;
        src_valid = '0; src_last = '0; src_data = '0;
        tb_out_ready = 1'b1; use_fifo = 1'b0; f_out_rdy = 1'b0;
        tick(e, g);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [NUM_SRC-1:0] e, g;
        rstn = 1'b0; clear = 1'b0;
        src_valid = 4'hF; src_last = '0; src_data = 32'h44332211;
        tb_out_ready = 1'b1; use_fifo = 1'b0; f_out_rdy = 1'b0;
        tick(e, g);
        tick(e, g);
        tests++; if (g !== 4'b0000) begin fails++; $display("FAIL reset_src_ready got %b exp 0000", g); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        tests++; if (out_src !== 2'd0) begin fails++; $display("FAIL reset_out_src got %0d exp 0", out_src); end
        tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL reset_out_last got %b exp 0", out_last); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        rstn = 1'b1;
        src_valid = '0;
    endtask

    task automatic test_rotation();
        logic [NUM_SRC-1:0] e, g;
        int s;
        do_reset();
        for (int i = 0; i < NUM_SRC; i++) src_data[i*DW +: DW] = {4'(i), 4'hA};
        src_valid = 4'hF;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rot_pre_valid got %b exp 0", out_valid); end
        for (int n = 0; n < 20; n++) begin
            s = (n / MAX_BURST) % NUM_SRC;
            tick(e, g);
            tests++; if (g !== 4'(1 << s)) begin fails++; $display("FAIL rot_ready beat %0d got %b exp %b", n, g, 4'(1 << s)); end
            tests++; if (out_valid !== 1'b1 || out_src !== 2'(s) || out_data !== {4'(s), 4'hA}) begin
                fails++; $display("FAIL rot_beat %0d got v%b src %0d data %h exp v1 src %0d", n, out_valid, out_src, out_data, s);
            end
        end
        src_valid = '0;
    endtask

    task automatic test_last_packet();
        logic [NUM_SRC-1:0] e, g;
        do_reset();
        src_valid = 4'b0100; src_data[2*DW +: DW] = 8'h21;
        tick(e, g);
        tests++; if (g !== 4'b0100) begin fails++; $display("FAIL last_ready got %b exp 0100", g); end
        tests++; if (out_src !== 2'd2 || out_data !== 8'h21 || out_last !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL last_beat0 got src %0d data %h last %b busy %b exp 2 21 0 1", out_src, out_data, out_last, busy);
        end
        src_data[2*DW +: DW] = 8'h22; src_last = 4'b0100;
        tick(e, g);
        tests++; if (out_src !== 2'd2 || out_data !== 8'h22 || out_last !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL last_beat1 got src %0d data %h last %b busy %b exp 2 22 1 0", out_src, out_data, out_last, busy);
        end
        src_valid = 4'b1001; src_last = '0;
        src_data[3*DW +: DW] = 8'h33; src_data[0 +: DW] = 8'h0F;
        tick(e, g);
        tests++; if (g !== 4'b1000 || out_src !== 2'd3) begin
            fails++; $display("FAIL last_next_grant got ready %b src %0d exp 1000 3", g, out_src);
        end
        src_valid = '0;
    endtask

    task automatic test_stall();
        logic [NUM_SRC-1:0] e, g;
        do_reset();
        src_valid = 4'b0010;
        src_data[1*DW +: DW] = 8'h11; tick(e, g);
        src_data[1*DW +: DW] = 8'h12; tick(e, g);
        tb_out_ready = 1'b0;
        src_data[1*DW +: DW] = 8'h13;
        for (int n = 0; n < 5; n++) begin
            tick(e, g);
            tests++; if (g !== 4'b0000) begin fails++; $display("FAIL stall_ready cyc %0d got %b exp 0000", n, g); end
            tests++; if (out_valid !== 1'b1 || out_data !== 8'h12 || out_src !== 2'd1 || out_last !== 1'b0 || busy !== 1'b1) begin
                fails++; $display("FAIL stall_hold cyc %0d got v%b data %h src %0d busy %b exp v1 12 1 1", n, out_valid, out_data, out_src, busy);
            end
        end
        tb_out_ready = 1'b1;
        tick(e, g);
        tests++; if (out_data !== 8'h13 || busy !== 1'b1) begin
            fails++; $display("FAIL stall_resume got data %h busy %b exp 13 1", out_data, busy);
        end
        src_data[1*DW +: DW] = 8'h14;
        tick(e, g);
        tests++; if (out_data !== 8'h14 || busy !== 1'b0) begin
            fails++; $display("FAIL stall_burst_end got data %h busy %b exp 14 0", out_data, busy);
        end
        src_valid = '0;
    endtask

    task automatic test_release();
        logic [NUM_SRC-1:0] e, g;
        do_reset();
        src_valid = 4'b0110;
        src_data[1*DW +: DW] = 8'hA1; src_data[2*DW +: DW] = 8'hB1;
        tick(e, g);
        tick(e, g);
        tests++; if (out_src !== 2'd1 || busy !== 1'b1) begin
            fails++; $display("FAIL rel_burst got src %0d busy %b exp 1 1", out_src, busy);
        end
        src_valid = 4'b0100;
        tick(e, g);
        tests++; if (g !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rel_cycle got ready %b v%b busy %b exp 0000 0 0", g, out_valid, busy);
        end
        tick(e, g);
        tests++; if (g !== 4'b0100 || out_src !== 2'd2 || out_data !== 8'hB1 || busy !== 1'b1) begin
            fails++; $display("FAIL rel_next got ready %b src %0d data %h busy %b exp 0100 2 B1 1", g, out_src, out_data, busy);
        end
        src_valid = '0;
    endtask

    task automatic test_clear();
        logic [NUM_SRC-1:0] e, g;
        do_reset();
        src_valid = 4'b0010; src_last = 4'b0010; src_data[1*DW +: DW] = 8'hC1;
        tick(e, g);
        src_valid = 4'b0100; src_last = '0; src_data[2*DW +: DW] = 8'hC2;
        tick(e, g);
        tick(e, g);
        tests++; if (busy !== 1'b1 || out_valid !== 1'b1 || out_src !== 2'd2) begin
            fails++; $display("FAIL clr_setup got busy %b v%b src %0d exp 1 1 2", busy, out_valid, out_src);
        end
        clear = 1'b1;
        tick(e, g);
        tests++; if (g !== 4'b0000) begin fails++; $display("FAIL clr_ready got %b exp 0000", g); end
        tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_src !== 2'd0 || out_data !== 8'h00) begin
            fails++; $display("FAIL clr_state got v%b busy %b src %0d data %h exp 0 0 0 00", out_valid, busy, out_src, out_data);
        end
        clear = 1'b0;
        src_valid = 4'b0101; src_data[0 +: DW] = 8'hC0;
        tick(e, g);
        tests++; if (g !== 4'b0001 || out_src !== 2'd0) begin
            fails++; $display("FAIL clr_rr got ready %b src %0d exp 0001 0", g, out_src);
        end
        src_valid = '0;
    endtask

    task automatic test_random();
        logic [NUM_SRC-1:0] e, g;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            src_data = $urandom;
            src_valid = 4'($urandom);
            for (int i = 0; i < NUM_SRC; i++) src_last[i] = ($urandom_range(3, 0) == 0);
            tb_out_ready = ($urandom_range(9, 0) < 7);
            clear = ($urandom_range(49, 0) == 0);
            tick(e, g);
            tests++; if (g !== e) begin fails++; $display("FAIL rnd_ready cyc %0d got %b exp %b", n, g, e); end
            tests++; if (out_valid !== m_ov) begin fails++; $display("FAIL rnd_valid cyc %0d got %b exp %b", n, out_valid, m_ov); end
            tests++; if (busy !== (m_owner >= 0)) begin fails++; $display("FAIL rnd_busy cyc %0d got %b exp %b", n, busy, (m_owner >= 0)); end
            if (m_ov) begin
                tests++; if ({out_last, out_src, out_data} !== {m_ol, m_os, m_od}) begin
                    fails++; $display("FAIL rnd_beat cyc %0d got l%b s%0d d%h exp l%b s%0d d%h", n, out_last, out_src, out_data, m_ol, m_os, m_od);
                end
            end
        end
        clear = 1'b0;
        src_valid = '0;
    endtask

    task automatic test_fifo();
        logic [NUM_SRC-1:0] e, g;
        int seq [NUM_SRC];
        int exp_seq [NUM_SRC];
        int received;
        int total;
        logic [10:0] beat;
        do_reset();
        use_fifo = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin seq[i] = 0; exp_seq[i] = 0; end
        received = 0;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                src_valid[i] = (seq[i] < 5);
                src_last[i]  = (seq[i] == 4);
                src_data[i*DW +: DW] = {2'(i), 6'(seq[i])};
            end
            tick(e, g);
            for (int i = 0; i < NUM_SRC; i++) if (g[i] && src_valid[i]) seq[i]++;
        end
        total = seq[0] + seq[1] + seq[2] + seq[3];
        tests++; if (f_count !== 4'd8) begin fails++; $display("FAIL fifo_stored got %0d exp 8", f_count); end
        tests++; if (total !== 9 || out_valid !== 1'b1) begin
            fails++; $display("FAIL fifo_accepted got %0d v%b exp 9 v1", total, out_valid);
        end
        f_out_rdy = 1'b1;
        for (int n = 0; n < 300 && received < 20; n++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                src_valid[i] = (seq[i] < 5);
                src_last[i]  = (seq[i] == 4);
                src_data[i*DW +: DW] = {2'(i), 6'(seq[i])};
            end
            if (f_out_vld) begin
                beat = f_out_dat;
                received++;
                tests++; if (beat[7:6] !== beat[9:8] || 32'(beat[5:0]) !== exp_seq[beat[9:8]] || beat[10] !== (beat[5:0] == 6'd4)) begin
                    fails++; $display("FAIL fifo_order got src %0d tag %0d seq %0d last %b exp seq %0d", beat[9:8], beat[7:6], beat[5:0], beat[10], exp_seq[beat[9:8]]);
                end
                exp_seq[beat[9:8]]++;
            end
            tick(e, g);
            for (int i = 0; i < NUM_SRC; i++) if (g[i] && src_valid[i]) seq[i]++;
        end
        tests++; if (received !== 20) begin fails++; $display("FAIL fifo_drain got %0d beats exp 20", received); end
        for (int i = 0; i < NUM_SRC; i++) begin
            tests++; if (exp_seq[i] !== 5) begin fails++; $display("FAIL fifo_src%0d got %0d beats exp 5", i, exp_seq[i]); end
        end
        tick(e, g);
        tests++; if (f_count !== 4'd0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL fifo_empty got count %0d v%b exp 0 0", f_count, out_valid);
        end
        use_fifo = 1'b0;
        f_out_rdy = 1'b0;
        src_valid = '0;
    endtask

    initial begin
        tests = 0; fails = 0;
        m_owner = -1; m_beats = 0; m_rr = 0;
        m_ov = 1'b0; m_ol = 1'b0; m_od = '0; m_os = '0;
        rstn = 1'b0; clear = 1'b0;
        src_valid = '0; src_last = '0; src_data = '0;
        tb_out_ready = 1'b1; use_fifo = 1'b0; f_out_rdy = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_rotation();
        test_last_packet();
        test_stall();
        test_release();
        test_clear();
        test_random();
        test_fifo();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
